// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: multi-cycle RV32I/RV32M ALU with valid/ready handshakes.
// Base ops complete one cycle after acceptance. MUL*/DIV*/REM* run on an
// iterative shift-add / restoring-divide datapath for XLEN cycles.
// Optional macro ALU_MULDIV_SHORTCUT_EN: divide-by-zero, signed overflow and
// multiply by zero complete in one cycle instead of running the iteration.
module alu_seq_muldiv #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        mop_q;     // op[2:0] of the running mul/div op
    logic [XLEN-1:0]   acc_hi_q;  // product high half / partial remainder
    logic [XLEN-1:0]   acc_lo_q;  // multiplier bits / dividend->quotient bits
    logic [XLEN-1:0]   opd_q;     // multiplicand or divisor magnitude
    logic [XLEN-1:0]   a_q;
    logic              neg_q;     // negate the final magnitude
    logic              dz_q;
    logic              ovf_q;

    logic [SHW-1:0]    shamt;
    logic [XLEN-1:0]   base_res;
    logic              is_muldiv;
    logic              is_div;
    logic              sgn_a;
    logic              sgn_b;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              neg_in;
    logic              dz_in;
    logic              ovf_in;
    logic              sc_hit;
    logic [XLEN-1:0]   sc_val;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [XLEN-1:0]   step_hi;
    logic [XLEN-1:0]   step_lo;
    logic [2*XLEN-1:0] prod;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   div_val;
    logic [XLEN-1:0]   final_res;

    // Single-cycle base ALU operating on the live inputs at acceptance.
    always_comb begin
        shamt    = b[SHW-1:0];
        base_res = '0;
        case (op)
            5'b00000: base_res = a + b;
            5'b00001: base_res = a - b;
            5'b00010: base_res = a & b;
            5'b00011: base_res = a | b;
            5'b00100: base_res = a ^ b;
            5'b00101: base_res = a << shamt;
            5'b00110: base_res = a >> shamt;
            5'b00111: base_res = $unsigned($signed(a) >>> shamt);
            5'b01000: base_res = {{(XLEN-1){1'b0}}, a < b};
            5'b01001: base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            5'b01010: base_res = {{(XLEN-1){1'b0}}, !(a < b)};
            5'b01011: base_res = {{(XLEN-1){1'b0}}, !($signed(a) < $signed(b))};
            default:  base_res = '0;
        endcase
    end

    // Operand conditioning for mul/div: magnitudes, result sign, special cases.
    always_comb begin
        is_muldiv = op[4] & ~op[3];
        is_div    = op[2];
        sgn_a     = is_div ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
        sgn_b     = is_div ? ~op[0] : (op[1:0] == 2'b01);
        a_neg     = sgn_a & a[XLEN-1];
        b_neg     = sgn_b & b[XLEN-1];
        a_mag     = a_neg ? -a : a;
        b_mag     = b_neg ? -b : b;
        // Remainder takes the dividend's sign; everything else the product sign.
        neg_in    = (is_div & op[1]) ? a_neg : (a_neg ^ b_neg);
        dz_in     = is_div & (b == '0);
        ovf_in    = is_div & ~op[0] & (a == XMIN) & (b == '1);
    end

`ifdef ALU_MULDIV_SHORTCUT_EN
    // Early-out detection for cases whose result is known at acceptance.
    always_comb begin
        sc_hit = is_muldiv & (is_div ? (dz_in | ovf_in) : (a == '0 || b == '0));
        sc_val = '0;
        if (is_div) begin
            if (dz_in) sc_val = op[1] ? a : '1;
            else       sc_val = op[1] ? '0 : a;
        end
    end
`else
    assign sc_hit = 1'b0;
    assign sc_val = '0;
`endif

    // One shift-add or restoring-divide step on the current accumulator.
    always_comb begin
        mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opd_q} : '0);
        div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opd_q};
        div_diff  = div_shift[XLEN-1:0] - opd_q;
        if (mop_q[2]) begin
            step_hi = div_ge ? div_diff : div_shift[XLEN-1:0];
            step_lo = {acc_lo_q[XLEN-2:0], div_ge};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], acc_lo_q[XLEN-1:1]};
        end
    end

    // Sign fix-up and half/special-case selection after the last step.
    always_comb begin
        prod      = {step_hi, step_lo};
        prod_s    = neg_q ? -prod : prod;
        div_val   = mop_q[1] ? step_hi : step_lo;
        final_res = '0;
        if (mop_q[2]) begin
            if (dz_q)       final_res = mop_q[1] ? a_q : '1;
            else if (ovf_q) final_res = mop_q[1] ? '0 : a_q;
            else            final_res = neg_q ? -div_val : div_val;
        end else begin
            final_res = (mop_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end
    end

    // Control FSM with registered handshake outputs and datapath state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            cnt_q     <= '0;
            mop_q     <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opd_q     <= '0;
            a_q       <= '0;
            neg_q     <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (is_muldiv && !sc_hit) begin
                            state_q  <= StBusy;
                            busy     <= 1'b1;
                            cnt_q    <= CW'(XLEN);
                            mop_q    <= op[2:0];
                            acc_hi_q <= '0;
                            acc_lo_q <= is_div ? a_mag : b_mag;
                            opd_q    <= is_div ? b_mag : a_mag;
                            a_q      <= a;
                            neg_q    <= neg_in;
                            dz_q     <= dz_in;
                            ovf_q    <= ovf_in;
                        end else begin
                            state_q   <= StDone;
                            out_valid <= 1'b1;
                            result    <= is_muldiv ? sc_val : base_res;
                        end
                    end
                end
                StBusy: begin
                    acc_hi_q <= step_hi;
                    acc_lo_q <= step_lo;
                    cnt_q    <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q   <= StDone;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        result    <= final_res;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q   <= StIdle;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Self-checking bench for alu_seq_muldiv (XLEN = 32): directed vector table,
// randomized ops against an arithmetic reference model, and hand sequences
// for result back-pressure and reset abort.
module tb_alu_seq_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        busy;

    int n_err = 0;
    int n_checks = 0;

    alu_seq_muldiv dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: RV32I/M semantics from plain arithmetic.
    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        logic [63:0] p;
        int sx;
        int sy;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            5'b00000: return x + y;
            5'b00001: return x - y;
            5'b00010: return x & y;
            5'b00011: return x | y;
            5'b00100: return x ^ y;
            5'b00101: return x << y[4:0];
            5'b00110: return x >> y[4:0];
            5'b00111: return $unsigned(sx >>> y[4:0]);
            5'b01000: return (x < y) ? 32'd1 : 32'd0;
            5'b01001: return (sx < sy) ? 32'd1 : 32'd0;
            5'b01010: return (x >= y) ? 32'd1 : 32'd0;
            5'b01011: return (sx >= sy) ? 32'd1 : 32'd0;
            5'b10000: return x * y;
            5'b10001: begin
                p = longint'(sx) * longint'(sy);
                return p[63:32];
            end
            5'b10010: begin
                p = longint'(sx) * longint'({32'b0, y});
                return p[63:32];
            end
            5'b10011: begin
                p = {32'b0, x} * {32'b0, y};
                return p[63:32];
            end
            5'b10100: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return x;
                return $unsigned(sx / sy);
            end
            5'b10101: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            5'b10110: begin
                if (y == 0) return x;
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
                return $unsigned(sx % sy);
            end
            5'b10111: return (y == 0) ? x : x % y;
            default:  return 32'd0;
        endcase
    endfunction

    // Edges from acceptance (inclusive) to the edge after which out_valid is seen.
    function automatic int exp_lat(input logic [4:0] o, input logic [31:0] x,
                                   input logic [31:0] y);
        if (o[4] && !o[3]) begin
`ifdef ALU_MULDIV_SHORTCUT_EN
            if (o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
                return 1;
            if (!o[2] && (x == 0 || y == 0))
                return 1;
`endif
            return 33;
        end
        return 1;
    endfunction

    // Issue one op from a negedge, scramble inputs after acceptance, wait for the result.
    task automatic do_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output int lat, output int bcnt);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready before issue", {31'b0, in_ready}, 32'd1);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op = 5'($urandom);
        a = $urandom;
        b = $urandom;
        lat = 1;
        bcnt = 0;
        while (!out_valid && lat < 100) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
        end
        r = result;
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t        vecs[$];
        logic [31:0] r;
        int          lat;
        int          bcnt;
        int          seen;

        vecs.push_back('{5'b00000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000});
        vecs.push_back('{5'b00111, 32'h8000_0000, 32'h0000_0021, 32'hC000_0000});
        vecs.push_back('{5'b00001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF});
        vecs.push_back('{5'b00010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200});
        vecs.push_back('{5'b00011, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F});
        vecs.push_back('{5'b00100, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00});
        vecs.push_back('{5'b00101, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000});
        vecs.push_back('{5'b00110, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001});
        vecs.push_back('{5'b01000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001});
        vecs.push_back('{5'b01001, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{5'b01010, 32'h0000_0005, 32'h0000_0005, 32'h0000_0001});
        vecs.push_back('{5'b01011, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000});
        vecs.push_back('{5'b01100, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000});
        vecs.push_back('{5'b11000, 32'h1234_5678, 32'h1111_1111, 32'h0000_0000});
        vecs.push_back('{5'b10000, 32'h0000_0003, 32'h0000_0004, 32'h0000_000C});
        vecs.push_back('{5'b10000, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000});
        vecs.push_back('{5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{5'b10010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF});
        vecs.push_back('{5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
        vecs.push_back('{5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
        vecs.push_back('{5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
        vecs.push_back('{5'b10101, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF});
        vecs.push_back('{5'b10111, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005});
        vecs.push_back('{5'b10100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD});
        vecs.push_back('{5'b10110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF});
        vecs.push_back('{5'b10100, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFF});
        vecs.push_back('{5'b10110, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB});

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset in_ready", {31'b0, in_ready}, 32'd1);
        check("reset out_valid", {31'b0, out_valid}, 32'd0);
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset result", result, 32'd0);

        // Directed vector table.
        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat, bcnt);
            check($sformatf("vec%0d op=%b result", i, vecs[i].op), r, vecs[i].exp);
            check($sformatf("vec%0d op=%b latency", i, vecs[i].op), lat,
                  exp_lat(vecs[i].op, vecs[i].a, vecs[i].b));
        end

        // MULHSU: busy lasts exactly XLEN cycles.
        do_op(5'b10010, 32'hFFFF_FFFF, 32'h0000_0002, r, lat, bcnt);
        check("mulhsu result", r, 32'hFFFF_FFFF);
        check("mulhsu busy cycles", bcnt, 32);
        check("mulhsu latency", lat, 33);

        // Result held under back-pressure.
        out_ready = 1'b0;
        op = 5'b10000;
        a = 32'd3;
        b = 32'd4;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a = 32'd99;
        b = 32'd77;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("hold latency", lat, exp_lat(5'b10000, 32'd3, 32'd4));
        for (int k = 0; k < 10; k++) begin
            check($sformatf("hold%0d result", k), result, 32'd12);
            check($sformatf("hold%0d out_valid", k), {31'b0, out_valid}, 32'd1);
            check($sformatf("hold%0d in_ready", k), {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release in_ready", {31'b0, in_ready}, 32'd1);
        check("release out_valid", {31'b0, out_valid}, 32'd0);

        // Reset aborts a DIVU in flight; no late result pulse.
        op = 5'b10101;
        a = 32'd1000;
        b = 32'd7;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("abort busy before rst", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort in_ready", {31'b0, in_ready}, 32'd1);
        check("abort out_valid", {31'b0, out_valid}, 32'd0);
        check("abort result", result, 32'd0);
        check("abort busy", {31'b0, busy}, 32'd0);
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid || busy) seen++;
            @(negedge clk);
        end
        check("abort no pulse", seen, 0);
        do_op(5'b00000, 32'd1, 32'd1, r, lat, bcnt);
        check("post-abort add", r, 32'd2);
        check("post-abort add latency", lat, 1);

        // Randomized ops against the reference model.
        for (int k = 0; k < 300; k++) begin
            logic [4:0]  o;
            logic [31:0] x;
            logic [31:0] y;
            o = 5'($urandom_range(0, 31));
            x = pick();
            y = pick();
            do_op(o, x, y, r, lat, bcnt);
            check($sformatf("rand%0d op=%b a=%h b=%h result", k, o, x, y), r, model(o, x, y));
            check($sformatf("rand%0d op=%b latency", k, o), lat, exp_lat(o, x, y));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_muldiv.md
Name: alu_seq_muldiv

Overview:
- Parametrised, multi-cycle successor to the single-cycle RV32I ALU.
- Executes all base ALU ops with registered 1-cycle latency, plus the RV32M multiply/divide ops on an iterative shift-add / restoring-divide datapath.
- Sits in the execute stage; connects to control through a valid/ready handshake on both the operand side and the result side.

Parameters:
- XLEN, 32, operand/result width; must be ≥ 8 and a power of two.
- SHW, $clog2(XLEN), shift-amount width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands/op presented
- in_ready  out  1  block can accept; high only in IDLE
- op  in  5  operation select; encoding below
- a  in  XLEN  operand A (rs1)
- b  in  XLEN  operand B (rs2/imm)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  result
- busy  out  1  high in BUSY state

Behaviour:
- Op encoding:
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR.
  - 00101 SLL, 00110 SRL, 00111 SRA.
  - 01000 SLTU, 01001 SLT, 01010 SGEU, 01011 SGE.
  - 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU.
  - 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU.
  - All others are undefined and give result 0 with normal 1-cycle latency.
- Shifts use b[SHW-1:0] only. SRA is arithmetic, sign = a[XLEN-1].
- Compares return zero-extended 0/1.
- Reset: state = IDLE; in_ready = 1, out_valid = 0, busy = 0, result = 0, iteration counter = 0.
  - rst wins over every other input in the same cycle.
  - rst during BUSY or DONE aborts the op and drops the result; no output pulse follows.
- Accept: edge E0 where in_valid & in_ready. op/a/b are captured at E0; later changes on the inputs are ignored.
- FSM:
  - IDLE -> DONE at E0 for base ops (op[4]=0). result is registered, so out_valid is high in the cycle after E0.
  - IDLE -> BUSY at E0 for MUL/DIV ops. The counter loads XLEN and decrements once per cycle; one partial product or one quotient bit per cycle.
  - BUSY -> DONE on the edge where the counter reaches 0, i.e. edge E0+XLEN. out_valid rises after that edge.
  - DONE -> IDLE on the edge with out_valid & out_ready. in_ready returns 1 in the next cycle; no back-to-back overlap.
  - DONE holds while out_ready = 0. result stays stable and out_valid stays high until accepted.
- Multiply:
  - Operands are sign/zero-extended to XLEN+1 per RV32M (MULH s×s, MULHSU s×u, MULHU u×u).
  - Product is 2·XLEN wide. MUL returns the low half; MULH* return the high half.
- Divide:
  - Magnitudes are divided unsigned; signs are fixed up at the end (quotient sign = sa^sb, remainder sign = sa).
  - b = 0: DIV/DIVU return all-ones, REM/REMU return a.
  - Signed overflow (a = most-negative, b = −1): DIV returns a, REM returns 0.
  - Without the optional feature, both special cases still take XLEN cycles.
- busy = (state == BUSY).

Optional Feature:
- ALU_MULDIV_SHORTCUT_EN.
- When defined:
  - Divide-by-zero, signed overflow, and multiply with a = 0 or b = 0 skip BUSY and go IDLE -> DONE at E0 (1-cycle latency).
  - Results are identical to the iterative path.
- When undefined: every op with op[4] = 1 takes exactly XLEN cycles in BUSY.

Test Plan:
- Reset, then ADD a=0x7FFFFFFF, b=1 -> out_valid in the cycle after E0, result = 0x80000000. SRA a=0x80000000, b=0x21 -> result = 0xC0000000 (shamt = 1).
- MULHSU a=0xFFFFFFFF, b=0x00000002 -> result = 0xFFFFFFFF. out_valid rises after E0+32. busy is high for exactly 32 cycles.
- DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000. REM same operands -> 0. DIVU a=5, b=0 -> 0xFFFFFFFF. REMU a=5, b=0 -> 5.
- DIV a=−7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF.
- Hold out_ready = 0 for 10 cycles after MUL 3×4 -> result stays 12, out_valid stays high, in_ready stays 0. Raise out_ready -> in_ready = 1 in the next cycle.
- Assert rst at cycle 10 of a DIVU -> next cycle in_ready = 1, out_valid = 0, result = 0. A following ADD 1+1 returns 2. Rerun the divide-by-zero case with ALU_MULDIV_SHORTCUT_EN defined -> 1-cycle latency.
